demux_16ch_tdm: RTL

DEMUX_16CH_TDM -- requirements
Module: demux_16ch_tdm

---
 rtl/demux_16ch_tdm.sv | 71 +++++++
 1 files changed

// File: rtl/demux_16ch_tdm.sv
// 16-channel serial TDM demultiplexer with frame-sync hunt/lock.
// A frame is only published on D once all 16 channel bits have arrived.
module demux_16ch_tdm (
    input  logic        clk,
    input  logic        rst,
    input  logic        E_N,
    input  logic        din,
    input  logic        frame_sync,
    output logic [15:0] D,
    output logic [3:0]  S,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic {
        HUNT    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    state_t      state;
    logic [14:0] shadow;

    assign locked = (state == RECEIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            S           <= 4'd0;
            D           <= 16'h0000;
            shadow      <= 15'h0000;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (!E_N) begin
                unique case (state)
                    HUNT: begin
                        if (frame_sync) begin
                            shadow[0] <= din;
                            S         <= 4'd1;
                            state     <= RECEIVE;
                        end
                    end
                    RECEIVE: begin
                        if (frame_sync) begin
                            // Early sync restarts the frame; stale shadow bits
                            // are overwritten before they can reach D.
                            sync_err  <= (S != 4'd0);
                            shadow[0] <= din;
                            S         <= 4'd1;
                        end else if (S == 4'd0) begin
                            sync_err <= 1'b1;
                            state    <= HUNT;
                        end else if (S == 4'd15) begin
                            D           <= {din, shadow};
                            frame_valid <= 1'b1;
                            S           <= 4'd0;
                        end else begin
                            shadow[S] <= din;
                            S         <= S + 4'd1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule
